// File: rtl/plot_write_arbiter_pkg.sv
// rtl/plot_write_arbiter_pkg.sv - shared constants, state and pixel types for the plot write arbiter
//
// Purpose: screen geometry, default field widths, arbiter state encoding and
// the packed pixel record shared by the arbiter, its request FIFO and benches.
// Ports: none (package).

package plot_write_arbiter_pkg;

   localparam int SCREEN_W     = 160;
   localparam int SCREEN_H     = 120;

   localparam int X_W_DEF      = 8;
   localparam int Y_W_DEF      = 7;
   localparam int COLOUR_W_DEF = 3;

   typedef enum logic {
      GAME  = 1'b0,
      CLEAR = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [X_W_DEF-1:0]      x;
      logic [Y_W_DEF-1:0]      y;
      logic [COLOUR_W_DEF-1:0] colour;
   } pixel_t;

endpackage

// File: rtl/plot_write_arbiter_req_fifo.sv
// rtl/plot_write_arbiter_req_fifo.sv - synchronous FIFO buffering game draw requests
//
// Purpose: strict-order FIFO of packed pixel words with registered occupancy.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high flush
//   push, push_data     write strobe and word (ignored while full)
//   pop, pop_data       read strobe (ignored while empty) and current head word
//   full, empty, count  status derived from the registered occupancy

module plot_req_fifo #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 18
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Storage is not reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/plot_write_arbiter.sv
// rtl/plot_write_arbiter.sv - merges the clear sweep and game draw requests onto the VGA write port
//
// Purpose: the clear sweep has absolute priority; game requests are buffered
// in plot_req_fifo and drained one per cycle while no clear is running.
// Optional feature macro: PLOT_ARB_BOUNDS_CHECK_EN (off-screen requests are
// accepted but discarded, counted on drop_count).
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   clr_active, clr_x, clr_y         clear sweep coordinate stream (no back-pressure)
//   req_valid, req_ready             game request handshake
//   req_x, req_y, req_colour         game request pixel
//   vga_x, vga_y, vga_colour         registered adapter pixel, held while not plotting
//   vga_plot                         registered adapter write enable
//   clear_done                       one-cycle pulse when the clear phase ends
//   fifo_count                       request FIFO occupancy
//   drop_count                       saturating off-screen drop counter (macro only)

module plot_write_arbiter
   import plot_write_arbiter_pkg::*;
#(
   parameter int                  FIFO_DEPTH   = 16,
   parameter int                  X_W          = X_W_DEF,
   parameter int                  Y_W          = Y_W_DEF,
   parameter int                  COLOUR_W     = COLOUR_W_DEF,
   parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clr_active,
   input  logic [X_W-1:0]                clr_x,
   input  logic [Y_W-1:0]                clr_y,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [X_W-1:0]                req_x,
   input  logic [Y_W-1:0]                req_y,
   input  logic [COLOUR_W-1:0]           req_colour,
   output logic [X_W-1:0]                vga_x,
   output logic [Y_W-1:0]                vga_y,
   output logic [COLOUR_W-1:0]           vga_colour,
   output logic                          vga_plot,
   output logic                          clear_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
   ,
   output logic [7:0]                    drop_count
`endif
);

   localparam int DATA_W = X_W + Y_W + COLOUR_W;

   arb_state_t        state;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              in_bounds;
   logic [DATA_W-1:0] head;

`ifdef PLOT_ARB_BOUNDS_CHECK_EN
   assign in_bounds = (32'(req_x) < SCREEN_W) && (32'(req_y) < SCREEN_H);

   // Off-screen requests still complete the handshake so the source never stalls on them.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_count <= '0;
      end else if (req_valid && req_ready && !in_bounds && (drop_count != 8'hFF)) begin
         drop_count <= drop_count + 8'd1;
      end
   end
`else
   assign in_bounds = 1'b1;
`endif

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign req_ready = !fifo_full;
   assign push      = req_valid && req_ready && in_bounds;
   // A clear pixel in the same cycle defers the pop; the exit cycle of CLEAR does not pop.
   assign pop       = !reset && !clr_active && (state == GAME) && !fifo_empty;

   plot_req_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({req_x, req_y, req_colour}),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= GAME;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= 1'b0;
         if (clr_active) begin
            state      <= CLEAR;
            vga_x      <= clr_x;
            vga_y      <= clr_y;
            vga_colour <= CLEAR_COLOUR;
            vga_plot   <= 1'b1;
         end else if (state == CLEAR) begin
            state      <= GAME;
            clear_done <= 1'b1;
            vga_plot   <= 1'b0;
         end else if (pop) begin
            {vga_x, vga_y, vga_colour} <= head;
            vga_plot   <= 1'b1;
         end else begin
            vga_plot   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_plot_write_arbiter.sv
// tb/tb_plot_write_arbiter.sv - self-checking bench for plot_write_arbiter

module tb_plot_write_arbiter;
   import plot_write_arbiter_pkg::*;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr_active = 1'b0;
   logic [7:0] clr_x = '0;
   logic [6:0] clr_y = '0;
   logic       req_valid = 1'b0;
   logic [7:0] req_x = '0;
   logic [6:0] req_y = '0;
   logic [2:0] req_colour = '0;
   logic       req_ready;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       clear_done;
   logic [4:0] fifo_count;
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
   logic [7:0] drop_count;
`endif

   always #5 clk = ~clk;

   plot_write_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .clr_active (clr_active),
      .clr_x      (clr_x),
      .clr_y      (clr_y),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_x      (req_x),
      .req_y      (req_y),
      .req_colour (req_colour),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .clear_done (clear_done),
      .fifo_count (fifo_count)
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
      ,
      .drop_count (drop_count)
`endif
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Reference model: a queue of buffered pixels plus the expected output registers.
   pixel_t q[$];
   pixel_t pend[$];
   bit     in_clear = 1'b0;
   pixel_t exp_px = '0;
   bit     exp_plot = 1'b0;
   bit     exp_done = 1'b0;
   bit     acc_last = 1'b0;
   int     first_acc = -1;
   int     m_drops = 0;
   bit     check_on = 1'b0;

   typedef struct {
      pixel_t p;
      int     cyc;
   } ent_t;
   ent_t plog[$];
   int   done_cnt = 0;
   int   done_cyc = -1;

   always @(posedge clk) begin
      bit     acc;
      bit     inb;
      pixel_t rp;
      cyc++;
      rp  = '{x: req_x, y: req_y, colour: req_colour};
      acc = !reset && req_valid && (q.size() < DEPTH);
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
      inb = (int'(req_x) < 160) && (int'(req_y) < 120);
`else
      inb = 1'b1;
`endif
      acc_last = acc;
      if (acc && first_acc < 0) first_acc = cyc;
      if (reset) begin
         q.delete();
         in_clear = 1'b0;
         exp_px   = '0;
         exp_plot = 1'b0;
         exp_done = 1'b0;
         m_drops  = 0;
      end else begin
         exp_done = 1'b0;
         if (clr_active) begin
            in_clear = 1'b1;
            exp_px   = '{x: clr_x, y: clr_y, colour: 3'd0};
            exp_plot = 1'b1;
         end else if (in_clear) begin
            in_clear = 1'b0;
            exp_done = 1'b1;
            exp_plot = 1'b0;
         end else if (q.size() > 0) begin
            exp_px   = q.pop_front();
            exp_plot = 1'b1;
         end else begin
            exp_plot = 1'b0;
         end
         if (acc && inb) q.push_back(rp);
         if (acc && !inb && m_drops < 255) m_drops++;
      end
   end

   always @(negedge clk) begin
      bit     exp_rdy;
      bit     drop_ok;
      pixel_t got;
      if (check_on) begin
         exp_rdy = (q.size() < DEPTH);
         got     = '{x: vga_x, y: vga_y, colour: vga_colour};
`ifdef PLOT_ARB_BOUNDS_CHECK_EN
         drop_ok = (drop_count === 8'(m_drops));
`else
         drop_ok = 1'b1;
`endif
         checks++;
         if (vga_plot !== exp_plot || got !== exp_px || clear_done !== exp_done ||
             fifo_count !== 5'(q.size()) || req_ready !== exp_rdy || !drop_ok) begin
            errors++;
            $display("FAIL cycle %0d: got plot=%b px=%h done=%b cnt=%0d rdy=%b drop_ok=%b, want plot=%b px=%h done=%b cnt=%0d rdy=%b",
                     cyc, vga_plot, got, clear_done, fifo_count, req_ready, drop_ok,
                     exp_plot, exp_px, exp_done, q.size(), exp_rdy);
         end
         if (vga_plot) plog.push_back('{p: got, cyc: cyc});
         if (clear_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic chk(input string name, input int act, input int want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   function automatic pixel_t log_px(input int i);
      if (i < plog.size()) return plog[i].p;
      return '1;
   endfunction

   function automatic pixel_t mk(input int x, input int y, input int c);
      return '{x: 8'(x), y: 7'(y), colour: 3'(c)};
   endfunction

   // One cycle of stimulus: retire an accepted request, then present the next inputs.
   task automatic tick(input bit clr, input int cx, input int cy, input bit rst);
      @(negedge clk);
      if (req_valid && acc_last) void'(pend.pop_front());
      reset      = rst;
      clr_active = clr;
      clr_x      = 8'(cx);
      clr_y      = 7'(cy);
      if (!rst && pend.size() > 0) begin
         req_valid  = 1'b1;
         req_x      = pend[0].x;
         req_y      = pend[0].y;
         req_colour = pend[0].colour;
      end else begin
         req_valid  = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) tick(1'b0, 0, 0, 1'b0);
   endtask

   task automatic clear_log();
      plog.delete();
      done_cnt  = 0;
      done_cyc  = -1;
      first_acc = -1;
   endtask

   initial begin
      int bad;
      int clr_left;
      int cx;
      int cy;

      tick(1'b0, 0, 0, 1'b1);
      tick(1'b0, 0, 0, 1'b1);
      tick(1'b0, 0, 0, 1'b0);
      check_on = 1'b1;
      chk("reset_plot", int'(vga_plot), 0);
      chk("reset_count", int'(fifo_count), 0);
      chk("reset_ready", int'(req_ready), 1);
      chk("reset_xy", int'(vga_x) + int'(vga_y) + int'(vga_colour), 0);

      // Three requests, no clear.
      clear_log();
      pend.push_back(mk(10, 5, 4));
      pend.push_back(mk(11, 5, 4));
      pend.push_back(mk(12, 5, 2));
      idle(8);
      chk("t1_plots", plog.size(), 3);
      chk("t1_first", int'(log_px(0)), int'(mk(10, 5, 4)));
      chk("t1_second", int'(log_px(1)), int'(mk(11, 5, 4)));
      chk("t1_third", int'(log_px(2)), int'(mk(12, 5, 2)));
      chk("t1_latency", (plog.size() > 0) ? plog[0].cyc : -1, first_acc + 1);
      chk("t1_no_done", done_cnt, 0);

      // Full-screen clear with 20 requests offered during it.
      clear_log();
      for (int i = 0; i < 20; i++) pend.push_back(mk(20 + i, i, 1 + (i % 7)));
      for (int i = 0; i < 19200; i++) begin
         tick(1'b1, i % 160, i / 160, 1'b0);
         if (i == 24) begin
            chk("t3_full_count", int'(fifo_count), 16);
            chk("t3_not_ready", int'(req_ready), 0);
         end
      end
      idle(45);
      bad = 0;
      for (int i = 0; i < 19200; i++)
         if (log_px(i) !== mk(i % 160, i / 160, 0)) bad++;
      chk("t2_sweep_bad", bad, 0);
      chk("t2_total_plots", plog.size(), 19220);
      chk("t2_contiguous", (plog.size() >= 19200) ? plog[19199].cyc - plog[0].cyc : -1, 19199);
      chk("t2_done_cnt", done_cnt, 1);
      chk("t2_done_cyc", done_cyc, (plog.size() >= 19200) ? plog[19199].cyc + 1 : -2);
      bad = 0;
      for (int i = 0; i < 20; i++)
         if (log_px(19200 + i) !== mk(20 + i, i, 1 + (i % 7))) bad++;
      chk("t3_drain_order_bad", bad, 0);

      // Clear rises on the cycle the head would pop.
      clear_log();
      pend.push_back(mk(30, 40, 5));
      pend.push_back(mk(31, 41, 6));
      tick(1'b0, 0, 0, 1'b0);
      tick(1'b1, 7, 7, 1'b0);
      tick(1'b1, 8, 7, 1'b0);
      tick(1'b1, 9, 7, 1'b0);
      idle(6);
      chk("t4_plots", plog.size(), 5);
      chk("t4_clear0", int'(log_px(0)), int'(mk(7, 7, 0)));
      chk("t4_clear2", int'(log_px(2)), int'(mk(9, 7, 0)));
      chk("t4_head", int'(log_px(3)), int'(mk(30, 40, 5)));
      chk("t4_next", int'(log_px(4)), int'(mk(31, 41, 6)));

      // Reset mid-drain with five entries still queued.
      for (int i = 0; i < 8; i++) pend.push_back(mk(50 + i, 60, 3));
      for (int i = 0; i < 10; i++) tick(1'b1, i, 0, 1'b0);
      for (int k = 0; k < 50; k++) begin
         if (q.size() <= 5) break;
         idle(1);
      end
      chk("t5_queued", int'(fifo_count), 5);
      tick(1'b0, 0, 0, 1'b1);
      idle(1);
      chk("t5_plot", int'(vga_plot), 0);
      chk("t5_count", int'(fifo_count), 0);
      chk("t5_ready", int'(req_ready), 1);
      idle(3);

`ifdef PLOT_ARB_BOUNDS_CHECK_EN
      clear_log();
      pend.push_back(mk(160, 0, 1));
      pend.push_back(mk(0, 120, 2));
      idle(6);
      chk("t6_no_plots", plog.size(), 0);
      chk("t6_drops", int'(drop_count), 2);
      chk("t6_pend_empty", pend.size(), 0);
`endif

      // Randomised traffic: requests, short clears, occasional resets.
      clr_left = 0;
      cx = 0;
      cy = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 30 && pend.size() < 40)
            pend.push_back(mk($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7)));
         if (clr_left == 0 && $urandom_range(0, 99) < 2) clr_left = $urandom_range(1, 30);
         if ($urandom_range(0, 399) == 0) begin
            tick(1'b0, 0, 0, 1'b1);
         end else if (clr_left > 0) begin
            cx = $urandom_range(0, 159);
            cy = $urandom_range(0, 119);
            tick(1'b1, cx, cy, 1'b0);
            clr_left--;
         end else begin
            tick(1'b0, 0, 0, 1'b0);
         end
      end
      idle(80);
      chk("rand_drained", int'(fifo_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
